// File: rtl/ram_bist_pkg.sv
// ram_bist_pkg: shared state encoding and test-pattern generator for the RAM
// built-in self-test controller and its compare stage.
package ram_bist_pkg;

    // Controller states; DRAIN absorbs the final read's one-cycle latency.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WRITE = 3'd1,
        READ  = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_t;

    // Widest address / data the pattern function can serve; callers cast the
    // result down to their own data width.
    localparam int PAT_MAX_A = 32;
    localparam int PAT_MAX_D = 64;

    // Bit i of the base word is address bit (i mod a_width); pass 1 inverts it.
    function automatic logic [PAT_MAX_D-1:0] pat(
        input logic [PAT_MAX_A-1:0] a,
        input logic                 p,
        input int                   a_width,
        input int                   d_width
    );
        logic [PAT_MAX_D-1:0] w;
        w = '0;
        for (int i = 0; i < PAT_MAX_D; i++) begin
            if (i < d_width) begin
                w[6'(i)] = a[5'(i % a_width)] ^ p;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/ram_bist_if.sv
// ram_bist_if: the RAM-facing bus of the BIST controller (write port, read
// address and registered read data). master = controller, slave = RAM.
interface ram_bist_if #(
    parameter int D_WIDTH = 16,
    parameter int A_WIDTH = 5
) ();
    logic [A_WIDTH-1:0] address_write;
    logic [D_WIDTH-1:0] data_write;
    logic               write_enable;
    logic [A_WIDTH-1:0] address_read;
    logic [D_WIDTH-1:0] data_read;

    modport master (
        output address_write,
        output data_write,
        output write_enable,
        output address_read,
        input  data_read
    );

    modport slave (
        input  address_write,
        input  data_write,
        input  write_enable,
        input  address_read,
        output data_read
    );
endinterface

// File: rtl/ram_bist_cmp.sv
// ram_bist_cmp: delays each issued read address by one cycle to line it up
// with the RAM's registered read data, compares against the expected pattern
// and keeps the sticky fail flag. With RAM_BIST_ERRLOG_EN defined it also
// logs address/expected/actual of the first mismatch of a run.
module ram_bist_cmp
    import ram_bist_pkg::*;
#(
    parameter int D_WIDTH = 16,
    parameter int A_WIDTH = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clear,       // start accepted: new run
    input  logic               rd_issue,    // a read address is on the bus this cycle
    input  logic [A_WIDTH-1:0] rd_addr,
    input  logic               pass,
    input  logic [D_WIDTH-1:0] data_read,
    output logic               fail,
    output logic [A_WIDTH-1:0] fail_addr,
    output logic [D_WIDTH-1:0] fail_expected,
    output logic [D_WIDTH-1:0] fail_actual
);

    logic               rd_vld_q, rd_vld_d;
    logic [A_WIDTH-1:0] rd_addr_q, rd_addr_d;
    logic               fail_q, fail_d;
    logic [D_WIDTH-1:0] exp_word;
    logic               mismatch;

    // Read-delay stage and sticky fail flag next-state.
    always_comb begin
        rd_vld_d  = rd_issue;
        rd_addr_d = rd_addr;
        exp_word  = D_WIDTH'(pat(PAT_MAX_A'(rd_addr_q), pass, A_WIDTH, D_WIDTH));
        mismatch  = rd_vld_q && (data_read != exp_word);
        fail_d    = clear ? 1'b0 : (fail_q | mismatch);
    end

    // Registers for the delay stage and fail flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_vld_q  <= 1'b0;
            rd_addr_q <= '0;
            fail_q    <= 1'b0;
        end else begin
            rd_vld_q  <= rd_vld_d;
            rd_addr_q <= rd_addr_d;
            fail_q    <= fail_d;
        end
    end

    assign fail = fail_q;

`ifdef RAM_BIST_ERRLOG_EN
    logic [A_WIDTH-1:0] log_addr_q, log_addr_d;
    logic [D_WIDTH-1:0] log_exp_q, log_exp_d;
    logic [D_WIDTH-1:0] log_act_q, log_act_d;

    // Capture only the first mismatch of a run (fail_q still low).
    always_comb begin
        log_addr_d = log_addr_q;
        log_exp_d  = log_exp_q;
        log_act_d  = log_act_q;
        if (clear) begin
            log_addr_d = '0;
            log_exp_d  = '0;
            log_act_d  = '0;
        end else if (mismatch && !fail_q) begin
            log_addr_d = rd_addr_q;
            log_exp_d  = exp_word;
            log_act_d  = data_read;
        end
    end

    // Error-log registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            log_addr_q <= '0;
            log_exp_q  <= '0;
            log_act_q  <= '0;
        end else begin
            log_addr_q <= log_addr_d;
            log_exp_q  <= log_exp_d;
            log_act_q  <= log_act_d;
        end
    end

    assign fail_addr     = log_addr_q;
    assign fail_expected = log_exp_q;
    assign fail_actual   = log_act_q;
`else
    assign fail_addr     = '0;
    assign fail_expected = '0;
    assign fail_actual   = '0;
`endif

endmodule

// File: rtl/ram_bist.sv
// ram_bist: two-pass write / read-compare self-test over every RAM address.
// Optional first-failure log is enabled by defining RAM_BIST_ERRLOG_EN.
//
// Handshake: start is a one-cycle request with no ready; it is accepted on a
// clock edge only while the controller is in IDLE or DONE and ignored
// otherwise. busy is high from the cycle after acceptance until DONE; done is
// a level that stays high until the next accepted start.
module ram_bist
    import ram_bist_pkg::*;
#(
    parameter int D_WIDTH = 16,
    parameter int A_WIDTH = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    output logic               busy,
    output logic               done,
    output logic               fail,
    output logic [A_WIDTH-1:0] fail_addr,
    output logic [D_WIDTH-1:0] fail_expected,
    output logic [D_WIDTH-1:0] fail_actual,
    output state_t             dbg_state,
    ram_bist_if.master         ram
);

    localparam int                 DEPTH = 2 ** A_WIDTH;
    localparam logic [A_WIDTH-1:0] LAST  = A_WIDTH'(DEPTH - 1);

    state_t             state_q, state_d;
    logic [A_WIDTH-1:0] counter_q, counter_d;
    logic               pass_q, pass_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               we_q, we_d;
    logic [A_WIDTH-1:0] aw_q, aw_d;
    logic [D_WIDTH-1:0] dw_q, dw_d;
    logic [A_WIDTH-1:0] ar_q, ar_d;
    logic               start_acc;

    // Next-state and registered-output logic; outputs are computed for the
    // state being entered so they appear on the bus in that state's cycles.
    always_comb begin
        state_d   = state_q;
        counter_d = counter_q;
        pass_d    = pass_q;
        busy_d    = busy_q;
        done_d    = done_q;
        we_d      = 1'b0;
        aw_d      = aw_q;
        dw_d      = dw_q;
        ar_d      = ar_q;
        start_acc = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    start_acc = 1'b1;
                    state_d   = WRITE;
                    counter_d = '0;
                    pass_d    = 1'b0;
                    busy_d    = 1'b1;
                    done_d    = 1'b0;
                    we_d      = 1'b1;
                    aw_d      = '0;
                end
            end
            WRITE: begin
                if (counter_q == LAST) begin
                    state_d   = READ;
                    counter_d = '0;
                    ar_d      = '0;
                end else begin
                    counter_d = counter_q + 1'b1;
                    we_d      = 1'b1;
                    aw_d      = counter_q + 1'b1;
                end
            end
            READ: begin
                if (counter_q == LAST) begin
                    state_d   = DRAIN;
                    counter_d = '0;
                end else begin
                    counter_d = counter_q + 1'b1;
                    ar_d      = counter_q + 1'b1;
                end
            end
            DRAIN: begin
                if (!pass_q) begin
                    state_d = WRITE;
                    pass_d  = 1'b1;
                    we_d    = 1'b1;
                    aw_d    = '0;
                end else begin
                    state_d = DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (we_d) begin
            dw_d = D_WIDTH'(pat(PAT_MAX_A'(aw_d), pass_d, A_WIDTH, D_WIDTH));
        end
    end

    // Controller state and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            counter_q <= '0;
            pass_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            we_q      <= 1'b0;
            aw_q      <= '0;
            dw_q      <= '0;
            ar_q      <= '0;
        end else begin
            state_q   <= state_d;
            counter_q <= counter_d;
            pass_q    <= pass_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            we_q      <= we_d;
            aw_q      <= aw_d;
            dw_q      <= dw_d;
            ar_q      <= ar_d;
        end
    end

    assign busy              = busy_q;
    assign done              = done_q;
    assign dbg_state         = state_q;
    assign ram.write_enable  = we_q;
    assign ram.address_write = aw_q;
    assign ram.data_write    = dw_q;
    assign ram.address_read  = ar_q;

    ram_bist_cmp #(
        .D_WIDTH (D_WIDTH),
        .A_WIDTH (A_WIDTH)
    ) u_cmp (
        .clk           (clk),
        .rst_n         (rst_n),
        .clear         (start_acc),
        .rd_issue      (state_q == READ),
        .rd_addr       (ar_q),
        .pass          (pass_q),
        .data_read     (ram.data_read),
        .fail          (fail),
        .fail_addr     (fail_addr),
        .fail_expected (fail_expected),
        .fail_actual   (fail_actual)
    );

endmodule

// File: tb/tb_ram_bist.sv
// tb_ram_bist: directed bench for ram_bist with a behavioural dual-port RAM
// that can inject a bit-0 stuck-at-0 read fault at address 7.
module tb_ram_bist;
    import ram_bist_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        busy;
    logic        done;
    logic        fail;
    logic [4:0]  fail_addr;
    logic [15:0] fail_expected;
    logic [15:0] fail_actual;
    state_t      dbg_state;
    logic        stuck_en;

    int n_cmp;
    int n_bad;

    ram_bist_if #(.D_WIDTH(16), .A_WIDTH(5)) ram_if ();

    ram_bist #(.D_WIDTH(16), .A_WIDTH(5)) u_dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .busy          (busy),
        .done          (done),
        .fail          (fail),
        .fail_addr     (fail_addr),
        .fail_expected (fail_expected),
        .fail_actual   (fail_actual),
        .dbg_state     (dbg_state),
        .ram           (ram_if)
    );

    // Clock / reset defaults
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural RAM: registered read, optional stuck-at-0 on bit 0 at addr 7
    logic [15:0] mem [0:31];
    logic [15:0] rd_word;
    always @(posedge clk) begin
        if (ram_if.write_enable) mem[ram_if.address_write] <= ram_if.data_write;
        rd_word = mem[ram_if.address_read];
        if (stuck_en && ram_if.address_read == 5'd7) rd_word[0] = 1'b0;
        ram_if.data_read <= rd_word;
    end

    // Driver: pulse start, optionally re-pulse at a given cycle, and watch the
    // run until done (bounded at 200 cycles).
    task automatic run_once(input int repulse_at, output int cycles, output int we_cycles,
                            output logic [15:0] w7_p0, output logic [15:0] w7_p1,
                            output int busy_low, output logic done0, output logic fail0);
        int hits;
        hits = 0; cycles = 0; we_cycles = 0; busy_low = 0;
        w7_p0 = '0; w7_p1 = '0;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        done0 = done;
        fail0 = fail;
        while (done !== 1'b1 && cycles < 200) begin
            start = (cycles == repulse_at) ? 1'b1 : 1'b0;
            if (busy !== 1'b1) busy_low++;
            if (ram_if.write_enable === 1'b1) begin
                we_cycles++;
                if (ram_if.address_write == 5'd7) begin
                    if (hits == 0) w7_p0 = ram_if.data_write;
                    else if (hits == 1) w7_p1 = ram_if.data_write;
                    hits++;
                end
            end
            @(posedge clk);
            #1;
            cycles++;
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        stuck_en = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if ({busy, done, fail, ram_if.write_enable} !== 4'b0) begin n_bad++; $display("FAIL reset_flags: got %b expected 0000", {busy, done, fail, ram_if.write_enable}); end
        n_cmp++; if ({ram_if.address_write, ram_if.address_read} !== 10'd0) begin n_bad++; $display("FAIL reset_addr: got %h expected 000", {ram_if.address_write, ram_if.address_read}); end
        n_cmp++; if (ram_if.data_write !== 16'h0) begin n_bad++; $display("FAIL reset_data: got %h expected 0000", ram_if.data_write); end
        n_cmp++; if ({fail_addr, fail_expected, fail_actual} !== 37'd0) begin n_bad++; $display("FAIL reset_log: got %h expected 0", {fail_addr, fail_expected, fail_actual}); end
        n_cmp++; if (dbg_state !== IDLE) begin n_bad++; $display("FAIL reset_state: got %0d expected %0d", dbg_state, IDLE); end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if ({busy, done, ram_if.write_enable} !== 3'b0 || dbg_state !== IDLE) begin n_bad++; $display("FAIL idle_hold: got %b/%0d expected 000/%0d", {busy, done, ram_if.write_enable}, dbg_state, IDLE); end
    endtask

    task automatic test_clean_run();
        int cyc, wec, bl;
        logic [15:0] p0, p1;
        logic d0, f0;
        stuck_en = 1'b0;
        run_once(-1, cyc, wec, p0, p1, bl, d0, f0);
        n_cmp++; if (cyc !== 130) begin n_bad++; $display("FAIL clean_latency: got %0d expected 130", cyc); end
        n_cmp++; if (fail !== 1'b0) begin n_bad++; $display("FAIL clean_fail: got %b expected 0", fail); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL clean_busy_end: got %b expected 0", busy); end
        n_cmp++; if (bl !== 0) begin n_bad++; $display("FAIL clean_busy_run: got %0d low cycles expected 0", bl); end
        n_cmp++; if (wec !== 64) begin n_bad++; $display("FAIL clean_we_count: got %0d expected 64", wec); end
        n_cmp++; if (p0 !== 16'h9CE7) begin n_bad++; $display("FAIL pat_p0_a7: got %h expected 9ce7", p0); end
        n_cmp++; if (p1 !== 16'h6318) begin n_bad++; $display("FAIL pat_p1_a7: got %h expected 6318", p1); end
        n_cmp++; if (dbg_state !== DONE) begin n_bad++; $display("FAIL clean_state: got %0d expected %0d", dbg_state, DONE); end
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (done !== 1'b1 || ram_if.write_enable !== 1'b0) begin n_bad++; $display("FAIL done_level: got %b%b expected 10", done, ram_if.write_enable); end
    endtask

    task automatic test_fault_log();
        int cyc, wec, bl;
        logic [15:0] p0, p1;
        logic d0, f0;
        stuck_en = 1'b1;
        run_once(-1, cyc, wec, p0, p1, bl, d0, f0);
        n_cmp++; if (cyc !== 130) begin n_bad++; $display("FAIL fault_latency: got %0d expected 130", cyc); end
        n_cmp++; if (fail !== 1'b1) begin n_bad++; $display("FAIL fault_flag: got %b expected 1", fail); end
`ifdef RAM_BIST_ERRLOG_EN
        n_cmp++; if (fail_addr !== 5'd7) begin n_bad++; $display("FAIL log_addr: got %0d expected 7", fail_addr); end
        n_cmp++; if (fail_expected !== 16'h9CE7) begin n_bad++; $display("FAIL log_expected: got %h expected 9ce7", fail_expected); end
        n_cmp++; if (fail_actual !== 16'h9CE6) begin n_bad++; $display("FAIL log_actual: got %h expected 9ce6", fail_actual); end
`else
        n_cmp++; if (fail_addr !== 5'd0) begin n_bad++; $display("FAIL log_addr: got %0d expected 0", fail_addr); end
        n_cmp++; if (fail_expected !== 16'h0) begin n_bad++; $display("FAIL log_expected: got %h expected 0000", fail_expected); end
        n_cmp++; if (fail_actual !== 16'h0) begin n_bad++; $display("FAIL log_actual: got %h expected 0000", fail_actual); end
`endif
    endtask

    task automatic test_back_to_back();
        int cyc, wec, bl;
        logic [15:0] p0, p1;
        logic d0, f0;
        stuck_en = 1'b1;
        run_once(40, cyc, wec, p0, p1, bl, d0, f0);
        n_cmp++; if (cyc !== 130) begin n_bad++; $display("FAIL busy_start_ignored: got %0d expected 130", cyc); end
        n_cmp++; if (fail !== 1'b1) begin n_bad++; $display("FAIL b2b_fault_flag: got %b expected 1", fail); end
        stuck_en = 1'b0;
        run_once(-1, cyc, wec, p0, p1, bl, d0, f0);
        n_cmp++; if ({d0, f0} !== 2'b00) begin n_bad++; $display("FAIL restart_clear: got done,fail=%b%b expected 00", d0, f0); end
        n_cmp++; if (cyc !== 130) begin n_bad++; $display("FAIL restart_latency: got %0d expected 130", cyc); end
        n_cmp++; if (fail !== 1'b0) begin n_bad++; $display("FAIL restart_fail: got %b expected 0", fail); end
`ifdef RAM_BIST_ERRLOG_EN
        n_cmp++; if (fail_addr !== 5'd0 || fail_expected !== 16'h0) begin n_bad++; $display("FAIL restart_log: got %0d/%h expected 0/0000", fail_addr, fail_expected); end
`endif
    endtask

    task automatic test_reset_mid_run();
        int cyc, wec, bl;
        logic [15:0] p0, p1;
        logic d0, f0;
        stuck_en = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (70) @(posedge clk);
        #1;
        n_cmp++; if (ram_if.write_enable !== 1'b1 || dbg_state !== WRITE) begin n_bad++; $display("FAIL midrun_pass1_write: got we=%b state=%0d expected 1/%0d", ram_if.write_enable, dbg_state, WRITE); end
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++; if ({busy, done, fail, ram_if.write_enable} !== 4'b0) begin n_bad++; $display("FAIL async_flags: got %b expected 0000", {busy, done, fail, ram_if.write_enable}); end
        n_cmp++; if ({ram_if.address_write, ram_if.address_read, ram_if.data_write} !== 26'd0) begin n_bad++; $display("FAIL async_bus: got %h expected 0", {ram_if.address_write, ram_if.address_read, ram_if.data_write}); end
        n_cmp++; if (dbg_state !== IDLE) begin n_bad++; $display("FAIL async_state: got %0d expected %0d", dbg_state, IDLE); end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        run_once(-1, cyc, wec, p0, p1, bl, d0, f0);
        n_cmp++; if (cyc !== 130) begin n_bad++; $display("FAIL post_reset_latency: got %0d expected 130", cyc); end
        n_cmp++; if (fail !== 1'b0 || wec !== 64) begin n_bad++; $display("FAIL post_reset_run: got fail=%b we=%0d expected 0/64", fail, wec); end
    endtask

    // Test sequence and final report
    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst_n = 1'b0;
        start = 1'b0;
        stuck_en = 1'b0;
        test_reset();
        test_clean_run();
        test_fault_log();
        test_back_to_back();
        test_reset_mid_run();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ram_bist.md
# ram_bist

Single-clock built-in self-test controller that drives the write and read ports of the team's dual-port `dut` RAM and checks the data it reads back. On a `start` pulse it runs a two-pass write/read-compare sweep over every address and then reports pass or fail. It sits beside the RAM instance: its outputs connect directly to the RAM ports, with `clk_write` and `clk_read` both tied to `clk`.

## Interface
Parameters:
- `D_WIDTH`, 16, RAM data width; must match the RAM.
- `A_WIDTH`, 5, RAM address width; depth is `DEPTH = 2**A_WIDTH`.

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  controller clock; the RAM's `clk_write` and `clk_read` are driven from the same net.
- `rst_n`  in  1  asynchronous active-low reset.
- `start`  in  1  one-cycle request; accepted only in IDLE or DONE.
- `busy`  out  1  high from the cycle after `start` is accepted until the test finishes.
- `done`  out  1  level; set at test end; cleared when the next `start` is accepted.
- `fail`  out  1  sticky; set on any mismatch; cleared when `start` is accepted.
- `address_write`  out  A_WIDTH  drives RAM `address_write`.
- `data_write`  out  D_WIDTH  drives RAM `data_write`.
- `write_enable`  out  1  drives RAM `write_enable`.
- `address_read`  out  A_WIDTH  drives RAM `address_read`.
- `data_read`  in  D_WIDTH  from RAM `data_read`; registered, 1-cycle read latency.
- `fail_addr`  out  A_WIDTH  first failing address (see Configuration).
- `fail_expected`  out  D_WIDTH  expected data at the first failure.
- `fail_actual`  out  D_WIDTH  actual data at the first failure.

## Operation
- Pattern function `pat(a, p)`:
  - bit i of the base word = `a[i mod A_WIDTH]`, for i in 0..D_WIDTH-1.
  - Pass p=0 uses the base word; pass p=1 uses its bitwise inverse.
- States and transitions:
  - IDLE → WRITE on `start`.
  - WRITE: `write_enable`=1; `address_write` = counter; `data_write` = `pat(counter, pass)`.
    - Counter runs 0..DEPTH-1.
    - At DEPTH-1 the counter wraps to 0 and the state moves to READ.
  - READ: `address_read` = counter, one address per cycle, 0..DEPTH-1.
    - The issued address is delayed one cycle (`rd_vld_q`, `rd_addr_q`).
    - When `rd_vld_q` is high, `data_read` is compared against `pat(rd_addr_q, pass)`.
    - After DEPTH-1 is issued, the state moves to DRAIN.
  - DRAIN: one cycle; the last comparison happens here.
    - Then: if pass=0, set pass=1 and go to WRITE; otherwise go to DONE.
  - DONE: `done`=1, `busy`=0. `start` returns to WRITE with pass=0.
- Mismatch: `fail` is set. It stays set through the rest of the run; the test never aborts early.
- `start` while `busy` is ignored.
- `write_enable` is 0 in every state except WRITE. Address and data outputs hold their last values when unused.

## Timing
- Reset values:
  - State IDLE; `busy`, `done`, `fail`, `write_enable` all 0.
  - All address, data and `fail_*` outputs 0.
  - Counter 0; pass 0.
- Reset asserted mid-run: all outputs return to reset values immediately (asynchronous), `write_enable` included. The RAM contents are then undefined to the bench.
- Cycle accounting:
  - `start` is sampled at edge 0; WRITE begins at edge 1.
  - Each pass takes DEPTH write cycles + DEPTH read cycles + 1 DRAIN cycle.
  - `done` rises 2·(2·DEPTH+1) cycles after `start` is accepted: 130 cycles for the defaults.
- Back-to-back: a `start` in the same cycle that DONE is entered is not seen. `start` is accepted from the first cycle in DONE onward.

## Configuration
- `RAM_BIST_ERRLOG_EN` defined:
  - On the first mismatch of a run, `fail_addr`, `fail_expected` and `fail_actual` capture `rd_addr_q`, the expected word and `data_read`.
  - Later mismatches do not overwrite them.
  - They are cleared when `start` is accepted.
- Not defined: the `fail_*` ports remain present but are tied to 0, and no capture registers are built.

## Structure
- Shared package `ram_bist_pkg` holds:
  - the state enum (IDLE, WRITE, READ, DRAIN, DONE);
  - the pattern function `pat`, parameterised on widths.
- One sub-module is natural: `ram_bist_cmp`, the 1-cycle read-delay plus compare stage, which also holds the optional error log.

## Test plan
- Clean RAM, defaults, `start` pulse → `done`=1 and `fail`=0 exactly 130 cycles later. `busy` is high throughout. `write_enable` is high for exactly 64 cycles total.
- Pattern check: during pass 0 at address 7, `data_write` = 16'h9CE7; during pass 1 at address 7, `data_write` = 16'h6318.
- Bench RAM model with bit 0 stuck-at-0 at address 7, macro defined → `fail`=1, `fail_addr`=7, `fail_expected`=16'h9CE7, `fail_actual`=16'h9CE6. `done` is still asserted at cycle 130.
- Same fault without the macro → `fail`=1; `fail_addr`, `fail_expected` and `fail_actual` all 0.
- `start` re-pulsed at cycle 40 → ignored. Then after `done`, `start` again → `done` and `fail` clear one cycle later, and a full new run completes.
- `rst_n` low at cycle 70, during pass 1 WRITE → outputs reach reset values without a clock edge. After release plus `start`, the run completes cleanly in 130 cycles.
